// File: rtl/ifft_normalize_if.sv
// Bus bundle for ifft_normalize: one input vector channel, one output vector channel.
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. A producer raising valid
// keeps its payload stable until that transfer. A consumer may drive ready
// from its own state only. Ready never depends on valid in the same cycle.
interface ifft_normalize_if #(
  parameter int K     = 8,
  parameter int LOG2N = 4
);
  localparam int W = K + 1;
  localparam int N = 1 << LOG2N;

  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             in_inv;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_data;

  // Block side of the bus.
  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side of the bus: drives vectors in and consumes results.
  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ifft_normalize.sv
// Post-IFFT normalisation over the Fermat ring Z/(2^K+1).
// The block captures a vector of N words. It then reduces one word per cycle,
// either as x mod M or as x*INV mod M, where INV = N^-1 mod M.
// The finished vector is presented until the consumer takes it.
module ifft_normalize #(
  parameter int K     = 8,
  parameter int LOG2N = 4
) (
  input  logic                clk,
  input  logic                rst,
  ifft_normalize_if.slave     bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int W = K + 1;
  localparam int N = 1 << LOG2N;
  localparam int M = (1 << K) + 1;

  // 2^(2K-LOG2N) mod M. Because 2^(2K) = 1 mod M, this is the inverse of N.
  function automatic int calc_inv();
    longint r;
    r = 1;
    for (int i = 0; i < 2*K - LOG2N; i++) r = (r * 2) % M;
    return int'(r);
  endfunction

  localparam int              INV   = calc_inv();
  localparam logic [W-1:0]    INV_W = W'(INV);
  localparam logic [K+1:0]    M_E   = (K+2)'(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LOG2N-1:0]   cnt;
  logic [N*W-1:0]     in_reg;
  logic               inv_reg;
  logic [N*W-1:0]     out_reg;
  logic               accept;

  logic [W-1:0]       x;
  logic [2*W-1:0]     prod;
  logic [K-1:0]       a0;
  logic [K-1:0]       a1;
  logic [1:0]         a2;
  logic [K+1:0]       s0;
  logic [K+1:0]       s1;
  logic [W-1:0]       res;

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_reg;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // FSM state register; reset overrides any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: accept in IDLE, leave RUN after the last word, release DONE on out_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (&cnt)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Exact modular reduction of the current word with a Fermat fold.
  // The product p is split as a0 + a1*2^K + a2*2^2K. Since 2^K = -1 mod M,
  // p = a0 - a1 + a2. Adding M keeps the sum non-negative and below 3M.
  // Two conditional subtractions then give a result in 0..M-1.
  always_comb begin
    x = in_reg[cnt*W +: W];
    if (inv_reg) prod = {{W{1'b0}}, x} * {{W{1'b0}}, INV_W};
    else         prod = {{W{1'b0}}, x};
    a0  = prod[K-1:0];
    a1  = prod[2*K-1:K];
    a2  = prod[2*W-1:2*K];
    s0  = {2'b00, a0} + {{K{1'b0}}, a2} + M_E - {2'b00, a1};
    s1  = (s0 >= M_E) ? (s0 - M_E) : s0;
    res = W'((s1 >= M_E) ? (s1 - M_E) : s1);
  end

  // Capture on accept; in RUN, write one reduced word per cycle into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      in_reg  <= '0;
      inv_reg <= 1'b0;
      out_reg <= '0;
    end else if (accept) begin
      in_reg  <= bus.in_data;
      inv_reg <= bus.in_inv;
      cnt     <= '0;
    end else if (state == RUN) begin
      out_reg[cnt*W +: W] <= res;
      cnt                 <= cnt + LOG2N'(1);
    end
  end

endmodule

// File: doc/ifft_normalize.md
IFFT_NORMALIZE -- requirements
Module: ifft_normalize

Interface
REQ-001 Parameter K, default 8: modulus M = 2^K+1 (default 257).
REQ-002 Parameter LOG2N, default 4: point count N = 2^LOG2N (default 16); legal range 1 <= LOG2N <= 2K.
REQ-003 Derived: word width W = K+1; vector width N*W (default 144); scale constant INV = 2^(2K-LOG2N) mod M (default 241 = 16^-1 mod 257).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  in_data/in_inv presented.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 in_data  input  N*W  packed vector; word i at bits [i*W+W-1 : i*W], word 0 at LSBs.
REQ-009 in_inv  input  1  1 = inverse mode (scale by INV); 0 = forward mode (reduce only).
REQ-010 out_valid  output  1  out_data holds a complete result vector.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  N*W  result vector, same packing as in_data.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States IDLE, RUN, DONE; the state register is the only control state besides the element counter.
REQ-015 in_ready = 1 exactly when state is IDLE (combinational from state, not from in_valid).
REQ-016 Accept edge: in_valid & in_ready; the edge latches in_data and in_inv into internal registers, clears the counter to 0, and moves IDLE -> RUN.
REQ-017 After acceptance, in_data/in_inv changes have no effect on the current vector.
REQ-018 In RUN, each edge processes word index = counter and writes it into the output register, then increments the counter; one word per cycle.
REQ-019 On the edge processing word N-1, state moves RUN -> DONE and the counter wraps to 0.
REQ-020 Latency: out_valid rises N cycles after the accept edge (default 16).
REQ-021 Arithmetic: treat each input word x as an unsigned integer 0..2^W-1. The result is (x*INV) mod M when in_inv=1, and x mod M when in_inv=0; the result is always 0..M-1 and is zero-extended to W bits.
REQ-022 Arithmetic is exact for every x including x >= M; intermediate products carry full 2W width (or an equivalent Fermat shift-and-fold); there is no truncation before reduction.
REQ-023 In DONE, out_valid = 1 and out_data is held stable until the handshake completes.
REQ-024 Output handshake: out_valid & out_ready on an edge moves DONE -> IDLE; out_valid falls on that edge.
REQ-025 out_ready low in DONE: the block holds indefinitely, with no data loss and no data change.
REQ-026 in_valid asserted while busy: ignored, with no capture and no state change.
REQ-027 A new vector can be accepted at the earliest one cycle after the output handshake; throughput is one vector per N+2 cycles under no backpressure.
REQ-028 out_data changes only during RUN writes; words not yet written in RUN hold their previous values, while out_valid = 0.
REQ-029 out_ready is ignored outside DONE.

Reset
REQ-030 rst = 1 on an edge: state = IDLE, counter = 0, out_valid = 0, busy = 0, out_data = 0, and the captured input and mode registers = 0.
REQ-031 Reset in any state (including mid-RUN or DONE) discards the in-flight vector; no partial result is ever presented with out_valid = 1.
REQ-032 rst has priority over every handshake on the same edge.
REQ-033 in_ready = 1 in the first cycle after reset deasserts.

Verification (K=8, LOG2N=4)
REQ-034 All words = 1, in_inv=1, out_ready=1 -> out_valid 16 cycles after acceptance; every word = 241.
REQ-035 Words {16, 256, 511, 0, 257, ...}, in_inv=1 -> results {1, 16, 48, 0, 0, ...}.
REQ-036 Same vector with in_inv=0 -> results {16, 256, 254, 0, 0, ...}.
REQ-037 out_ready held low 20 cycles in DONE, with in_valid pulsed meanwhile -> out_data stable, in_ready = 0, the pulse is not captured, and out_valid drops one edge after out_ready rises.
REQ-038 rst asserted at RUN counter = 7 -> next cycle IDLE, out_valid = 0, out_data = 0; a following vector completes normally with correct values.
REQ-039 Back-to-back vectors with in_valid held high -> accepts are spaced 18 cycles apart, and each output matches its own input.
